reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised multi-port register file with write bypass, deterministic write-port priority and a per-register busy scoreboard. Serves as the CPU datapath's architectural register store. The scoreboard marks registers with an outstanding long-latency write (e.g. a memory load) so issue logic can stall on read-after-write hazards. It generalises the 2-read/1-write file to R read ports and W write ports.

## Interface
- WIDTH, 8, data width of each register
- LENGTH, 4, number of registers; ADDR_WIDTH = $clog2(LENGTH)
- RD_PORTS, 2, number of read ports (1..4)
- WR_PORTS, 2, number of write ports (1..2)
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; synchronous, active-high
- rd_addr  in  RD_PORTS*ADDR_WIDTH  read addresses, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  RD_PORTS*WIDTH  read data, port i at [i*WIDTH +: WIDTH]
- rd_busy  out  RD_PORTS  port i's register has a pending write not completing this cycle
- wr_en  in  WR_PORTS  write enable per port
- wr_addr  in  WR_PORTS*ADDR_WIDTH  write addresses
- wr_data  in  WR_PORTS*WIDTH  write data
- sb_set  in  1  mark register sb_addr busy (pending write issued)
- sb_addr  in  ADDR_WIDTH  register to mark busy
- sb_err  out  1  sticky; sb_set hit an already-busy register not being cleared that cycle

## Operation
- Write: on posedge, each port p with wr_en[p] stores wr_data[p] at wr_addr[p].
- Same address on both write ports: port 1 wins; port 0 data discarded; no error.
- Read: combinational. If any enabled write port targets rd_addr[i], rd_data[i] is that port's wr_data, highest-index port winning. Otherwise rd_data[i] is the stored value.
- Scoreboard: busy bit per register.
  - Clear: any enabled write to a register clears its busy bit at posedge.
  - Set: sb_set sets busy[sb_addr] at posedge.
  - Set and clear of the same register in one cycle: set wins; busy stays 1.
- rd_busy[i] = busy[rd_addr[i]] & ~(an enabled write to rd_addr[i] this cycle). A completing write bypasses, so it does not stall.
- sb_err: set when sb_set hits a register that is busy and not being cleared that cycle. Stays 1 until rst. The busy bit remains 1.
- Reset: all registers 0, all busy bits 0, sb_err 0. Pending writes are forgotten. A write completing in the reset cycle is dropped.

## Timing
- Read latency 0 cycles, including bypass.
- Write visible in storage one cycle after wr_en; visible through bypass in the same cycle.
- Busy set takes effect on rd_busy from the cycle after sb_set.
- Busy clear takes effect on rd_busy in the same cycle as the clearing write.
- sb_err rises the cycle after the offending sb_set.
- Reset values: rd_data = stored 0 unless bypassed; rd_busy 0; sb_err 0 from the cycle after rst is sampled.

## Configuration
- Macro `REG_FILE_ZERO_REG_EN`.
- Defined:
  - Register 0 is hard-wired to zero.
  - Writes to address 0 are discarded, including for bypass: reads of 0 always return 0.
  - sb_set to 0 is ignored: no busy bit set, no sb_err.
  - rd_busy for address 0 is always 0.
- Undefined: register 0 behaves as every other register.

## Structure
- Package `reg_file_pkg` holds:
  - default WIDTH/LENGTH constants
  - regaddr_t and regdata_t typedefs, derived from the defaults
  - helper function for write-port priority select
- Sub-module `reg_scoreboard` holds the busy vector, set/clear priority, rd_busy generation and sb_err. It takes wr_en/wr_addr, sb_set/sb_addr and rd_addr.
- The storage array, write decode and bypass muxes stay in reg_file_sb.

## Test plan
Configuration: WIDTH=8, LENGTH=4, RD_PORTS=2, WR_PORTS=2.

- Reset, then write 0xAA@0, 0xBB@1, 0xCC@2, 0xDD@3 via port 0 → rd_addr={3,0} gives {0xDD,0xAA}; rd_addr={2,1} gives {0xCC,0xBB}.
- Same cycle: port0 writes 0x11@2, port1 writes 0x22@2, rd_addr0=2 → bypass reads 0x22; next cycle stored value is 0x22.
- sb_set@1, next cycle rd_addr0=1 → rd_busy[0]=1. Port1 writes 0x5A@1 → rd_busy[0]=0 and rd_data[0]=0x5A in that same cycle; busy cleared afterwards.
- Reg 3 busy; sb_set@3 with port0 writing 3 in the same cycle → busy stays 1, sb_err stays 0. Then sb_set@3 again with no write → sb_err=1 next cycle and held.
- Reg 2 busy, sb_err=1, rst asserted for one cycle mid-operation → all registers read 0x00, rd_busy 0, sb_err 0.
- With `REG_FILE_ZERO_REG_EN`: write 0xFF@0 and sb_set@0 → rd_data for address 0 is 0x00 both same-cycle and next cycle; rd_busy 0; sb_err 0.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults, register typedefs and write-port priority helper for reg_file_sb.
package reg_file_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_LENGTH = 4;
    localparam int DEF_ADDR_WIDTH = $clog2(DEF_LENGTH);
    localparam int MAX_WR_PORTS = 2;
    typedef logic [DEF_ADDR_WIDTH-1:0] regaddr_t;
    typedef logic [DEF_WIDTH-1:0] regdata_t;
    // Highest-index hitting port wins, matching the storage write order.
    function automatic int wr_pick(input logic [MAX_WR_PORTS-1:0] hit);
        wr_pick = 0;
        for (int p = 0; p < MAX_WR_PORTS; p++)
            if (hit[p]) wr_pick = p;
    endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register busy bits with set-over-clear priority, rd_busy lookup and sticky sb_err.
module reg_scoreboard #(
    parameter int LENGTH = 4,
    parameter int RD_PORTS = 2,
    parameter int WR_PORTS = 2,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WR_PORTS-1:0]            wr_en,
    input  logic [WR_PORTS*ADDR_WIDTH-1:0] wr_addr,
    input  logic                           sb_set,
    input  logic [ADDR_WIDTH-1:0]          sb_addr,
    input  logic [RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [RD_PORTS-1:0]            rd_busy,
    output logic                           sb_err
);
    logic [LENGTH-1:0] busy_q, busy_d, clr, set;
    logic err_q, err_d;
    always_comb begin
        clr = '0;
        set = '0;
        for (int r = 0; r < LENGTH; r++) begin
            for (int p = 0; p < WR_PORTS; p++)
                if (wr_en[p] && wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r)) clr[r] = 1'b1;
            set[r] = sb_set && sb_addr == ADDR_WIDTH'(r);
        end
        busy_d = (busy_q & ~clr) | set;
        err_d = err_q | (|(set & busy_q & ~clr));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            err_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q <= err_d;
        end
    end
    // A write completing this cycle bypasses its data, so it must not stall the reader.
    for (genvar r = 0; r < RD_PORTS; r++) begin : g_busy
        logic [ADDR_WIDTH-1:0] ra;
        assign ra = rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
        assign rd_busy[r] = busy_q[ra] & ~clr[ra];
    end
    assign sb_err = err_q;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: R-read/W-write register file with same-cycle write bypass and busy scoreboard.
// Define REG_FILE_ZERO_REG_EN to hard-wire register 0 to zero (writes and sb_set to it ignored).
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LENGTH = DEF_LENGTH,
    parameter int RD_PORTS = 2,
    parameter int WR_PORTS = 2,
    localparam int ADDR_WIDTH = $clog2(LENGTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [RD_PORTS*ADDR_WIDTH-1:0] rd_addr,
    output logic [RD_PORTS*WIDTH-1:0]      rd_data,
    output logic [RD_PORTS-1:0]            rd_busy,
    input  logic [WR_PORTS-1:0]            wr_en,
    input  logic [WR_PORTS*ADDR_WIDTH-1:0] wr_addr,
    input  logic [WR_PORTS*WIDTH-1:0]      wr_data,
    input  logic                           sb_set,
    input  logic [ADDR_WIDTH-1:0]          sb_addr,
    output logic                           sb_err
);
    logic [WR_PORTS-1:0] we;
    logic sb_set_eff;
    logic [WIDTH-1:0] mem_q [LENGTH];
    logic [WIDTH-1:0] mem_d [LENGTH];
`ifdef REG_FILE_ZERO_REG_EN
    // Dropping writes to register 0 here also removes them from bypass and busy-clear.
    always_comb begin
        we = '0;
        for (int p = 0; p < WR_PORTS; p++)
            we[p] = wr_en[p] && wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] != '0;
    end
    assign sb_set_eff = sb_set && sb_addr != '0;
`else
    assign we = wr_en;
    assign sb_set_eff = sb_set;
`endif
    always_comb begin
        mem_d = mem_q;
        for (int p = 0; p < WR_PORTS; p++)
            if (we[p]) mem_d[wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] = wr_data[p*WIDTH +: WIDTH];
    end
    always_ff @(posedge clk) begin
        if (rst) mem_q <= '{default: '0};
        else mem_q <= mem_d;
    end
    for (genvar r = 0; r < RD_PORTS; r++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [MAX_WR_PORTS-1:0] hit;
        assign ra = rd_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
        always_comb begin
            hit = '0;
            for (int p = 0; p < WR_PORTS; p++)
                hit[p] = we[p] && wr_addr[p*ADDR_WIDTH +: ADDR_WIDTH] == ra;
        end
        assign rd_data[r*WIDTH +: WIDTH] = |hit ? wr_data[wr_pick(hit)*WIDTH +: WIDTH] : mem_q[ra];
    end
    reg_scoreboard #(
        .LENGTH(LENGTH),
        .RD_PORTS(RD_PORTS),
        .WR_PORTS(WR_PORTS),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_sb (
        .clk(clk),
        .rst(rst),
        .wr_en(we),
        .wr_addr(wr_addr),
        .sb_set(sb_set_eff),
        .sb_addr(sb_addr),
        .rd_addr(rd_addr),
        .rd_busy(rd_busy),
        .sb_err(sb_err)
    );
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed vector table plus randomized run against a rule-level model.
module tb_reg_file_sb;
`ifdef REG_FILE_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif
    logic clk = 1'b0, rst = 1'b1;
    logic [3:0] rd_addr = '0;
    logic [15:0] rd_data;
    logic [1:0] rd_busy;
    logic [1:0] wr_en = '0;
    logic [3:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic sb_set = 1'b0;
    logic [1:0] sb_addr = '0;
    logic sb_err;
    int checks = 0, errors = 0;

    reg_file_sb dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_set(sb_set), .sb_addr(sb_addr), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst; logic [1:0] we; logic [3:0] wa; logic [15:0] wd;
        logic sb; logic [1:0] sa; logic [3:0] ra;
        logic [15:0] rd; logic [1:0] busy; logic err;
    } vec_t;
    vec_t tbl[22];

    logic [7:0] m_regs [4];
    logic [3:0] m_busy;
    logic m_err;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t v(logic r, logic [1:0] we, logic [3:0] wa, logic [15:0] wd, logic sb,
                               logic [1:0] sa, logic [3:0] ra, logic [15:0] rd, logic [1:0] busy, logic err);
        vec_t t;
        t.rst = r; t.we = we; t.wa = wa; t.wd = wd; t.sb = sb; t.sa = sa;
        t.ra = ra; t.rd = rd; t.busy = busy; t.err = err;
        return t;
    endfunction

    function automatic logic written(input logic [1:0] a);
        logic w = 1'b0;
        for (int p = 0; p < 2; p++)
            if (wr_en[p] && wr_addr[p*2 +: 2] == a && !(ZR && a == 0)) w = 1'b1;
        return w;
    endfunction

    function automatic logic [7:0] m_rd(input logic [1:0] a);
        logic [7:0] d = m_regs[a];
        for (int p = 0; p < 2; p++)
            if (wr_en[p] && wr_addr[p*2 +: 2] == a && !(ZR && a == 0)) d = wr_data[p*8 +: 8];
        return d;
    endfunction

    task automatic model_update();
        logic [3:0] clr;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_regs[i] = '0;
            m_busy = '0;
            m_err = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) clr[i] = written(2'(i));
            if (sb_set && !(ZR && sb_addr == 0) && m_busy[sb_addr] && !clr[sb_addr]) m_err = 1'b1;
            m_busy = m_busy & ~clr;
            if (sb_set && !(ZR && sb_addr == 0)) m_busy[sb_addr] = 1'b1;
            for (int p = 0; p < 2; p++)
                if (wr_en[p] && !(ZR && wr_addr[p*2 +: 2] == 0)) m_regs[wr_addr[p*2 +: 2]] = wr_data[p*8 +: 8];
        end
    endtask

    initial begin
        tbl[0]  = v(0, 2'b00, 4'b0000, 16'h0000, 0, 0, 4'b1100, 16'h0000, 2'b00, 0);
        tbl[1]  = v(0, 2'b01, 4'b0000, 16'h00AA, 0, 0, 4'b0000, 16'hAAAA, 2'b00, 0);
        tbl[2]  = v(0, 2'b01, 4'b0001, 16'h00BB, 0, 0, 4'b0001, 16'hAABB, 2'b00, 0);
        tbl[3]  = v(0, 2'b01, 4'b0010, 16'h00CC, 0, 0, 4'b0101, 16'hBBBB, 2'b00, 0);
        tbl[4]  = v(0, 2'b01, 4'b0011, 16'h00DD, 0, 0, 4'b1011, 16'hCCDD, 2'b00, 0);
        tbl[5]  = v(0, 2'b00, 4'b0000, 16'h0000, 0, 0, 4'b1100, 16'hDDAA, 2'b00, 0);
        tbl[6]  = v(0, 2'b00, 4'b0000, 16'h0000, 0, 0, 4'b1001, 16'hCCBB, 2'b00, 0);
        tbl[7]  = v(0, 2'b11, 4'b1010, 16'h2211, 0, 0, 4'b1010, 16'h2222, 2'b00, 0);
        tbl[8]  = v(0, 2'b00, 4'b0000, 16'h0000, 0, 0, 4'b0010, 16'hAA22, 2'b00, 0);
        tbl[9]  = v(0, 2'b00, 4'b0000, 16'h0000, 1, 1, 4'b0101, 16'hBBBB, 2'b00, 0);
        tbl[10] = v(0, 2'b00, 4'b0000, 16'h0000, 0, 0, 4'b0001, 16'hAABB, 2'b01, 0);
        tbl[11] = v(0, 2'b10, 4'b0100, 16'h5A00, 0, 0, 4'b0101, 16'h5A5A, 2'b00, 0);
        tbl[12] = v(0, 2'b00, 4'b0000, 16'h0000, 0, 0, 4'b0101, 16'h5A5A, 2'b00, 0);
        tbl[13] = v(0, 2'b00, 4'b0000, 16'h0000, 1, 3, 4'b1111, 16'hDDDD, 2'b00, 0);
        tbl[14] = v(0, 2'b01, 4'b0011, 16'h0033, 1, 3, 4'b1111, 16'h3333, 2'b00, 0);
        tbl[15] = v(0, 2'b00, 4'b0000, 16'h0000, 0, 0, 4'b1111, 16'h3333, 2'b11, 0);
        tbl[16] = v(0, 2'b00, 4'b0000, 16'h0000, 1, 3, 4'b1111, 16'h3333, 2'b11, 0);
        tbl[17] = v(0, 2'b00, 4'b0000, 16'h0000, 0, 0, 4'b1111, 16'h3333, 2'b11, 1);
        tbl[18] = v(0, 2'b00, 4'b0000, 16'h0000, 1, 2, 4'b1011, 16'h2233, 2'b01, 1);
        tbl[19] = v(1, 2'b01, 4'b0001, 16'h0077, 0, 0, 4'b1011, 16'h2233, 2'b11, 1);
        tbl[20] = v(0, 2'b00, 4'b0000, 16'h0000, 0, 0, 4'b0100, 16'h0000, 2'b00, 0);
        tbl[21] = v(0, 2'b00, 4'b0000, 16'h0000, 0, 0, 4'b1110, 16'h0000, 2'b00, 0);
        repeat (2) @(posedge clk);
        for (int i = 0; i < 22; i++) begin
            logic [15:0] exp_rd;
            @(negedge clk);
            rst = tbl[i].rst; wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
            sb_set = tbl[i].sb; sb_addr = tbl[i].sa; rd_addr = tbl[i].ra;
            exp_rd = tbl[i].rd;
            for (int s = 0; s < 2; s++)
                if (ZR && tbl[i].ra[s*2 +: 2] == 0) exp_rd[s*8 +: 8] = 8'h00;
            #1;
            check($sformatf("row%0d rd_data", i), 32'(rd_data), 32'(exp_rd));
            check($sformatf("row%0d rd_busy", i), 32'(rd_busy), 32'(tbl[i].busy));
            check($sformatf("row%0d sb_err", i), 32'(sb_err), 32'(tbl[i].err));
        end
`ifdef REG_FILE_ZERO_REG_EN
        @(negedge clk);
        rst = 0; wr_en = 2'b01; wr_addr = 4'b0000; wr_data = 16'h00FF;
        sb_set = 1; sb_addr = 0; rd_addr = 4'b0000;
        #1;
        check("zr same-cycle rd", 32'(rd_data), 32'h0);
        check("zr same-cycle busy", 32'(rd_busy), 32'h0);
        @(negedge clk);
        wr_en = 0; sb_set = 0;
        #1;
        check("zr next rd", 32'(rd_data), 32'h0);
        check("zr next busy", 32'(rd_busy), 32'h0);
        @(negedge clk);
        sb_set = 1; sb_addr = 0;
        @(negedge clk);
        sb_set = 0;
        #1;
        check("zr sb_err", 32'(sb_err), 32'h0);
`endif
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_busy = '0;
        m_err = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rst = (c == 0) || ($urandom_range(0, 63) == 0);
            wr_en = 2'($urandom);
            wr_addr = 4'($urandom);
            wr_data = 16'($urandom);
            sb_set = ($urandom_range(0, 2) == 0);
            sb_addr = 2'($urandom);
            rd_addr = 4'($urandom);
            #1;
            if (c > 0) begin
                for (int s = 0; s < 2; s++) begin
                    check($sformatf("rand%0d rd_data[%0d]", c, s), 32'(rd_data[s*8 +: 8]), 32'(m_rd(rd_addr[s*2 +: 2])));
                    check($sformatf("rand%0d rd_busy[%0d]", c, s), 32'(rd_busy[s]),
                          32'(m_busy[rd_addr[s*2 +: 2]] && !written(rd_addr[s*2 +: 2])));
                end
                check($sformatf("rand%0d sb_err", c), 32'(sb_err), 32'(m_err));
            end
            @(posedge clk);
            model_update();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
